// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic
// N-deep elastic pipeline register carrying a data bundle and a control
// bundle between two core stages. Every slot has its own valid bit. A slot
// moves forward when the slot ahead of it is empty or moving this cycle.
// The ready signal is resolved combinationally from the last slot back to
// slot 0. Empty slots always carry an all-zero control bundle, so a bubble
// can never trigger a register write or CSR side effect downstream.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   in_valid / in_ready   upstream handshake (slot 0)
//   in_data, in_ctrl      upstream data / control bundle
//   out_valid / out_ready downstream handshake (last slot)
//   out_data, out_ctrl    last-slot bundles; out_ctrl is zero when !out_valid
//   flush                 discards every in-flight beat; blocks both handshakes
//   occupancy             registered count of valid slots (0..STAGES)
//
// Optional build macro PIPE_STAGE_PERF_CNT_EN adds saturating counters:
//   stall_cnt  (32b) cycles with out_valid && !out_ready
//   bubble_cnt (32b) cycles with !out_valid && !flush
//   flush_cnt  (16b) cycles with flush asserted
//
// Parameters: DATA_W, CTRL_W, STAGES (1..8), DATA_RST_EN (1 = data is also
// cleared on reset, flush and drain; 0 = data registers simply hold).
module pipe_stage_elastic #(
  parameter int DATA_W      = 128,
  parameter int CTRL_W      = 6,
  parameter int STAGES      = 1,
  parameter int DATA_RST_EN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [3:0]        occupancy
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] adv;
  logic [DATA_W-1:0] data_q [STAGES];
  logic [DATA_W-1:0] data_d [STAGES];
  logic [CTRL_W-1:0] ctrl_q [STAGES];
  logic [CTRL_W-1:0] ctrl_d [STAGES];
  logic [3:0]        occ_q, occ_d;
  logic              take, emit;

  // Value a data register takes when its slot is emptied.
  function automatic logic [DATA_W-1:0] clr_data(input logic [DATA_W-1:0] d);
    return (DATA_RST_EN != 0) ? '0 : d;
  endfunction

  // ---- ready chain: last slot back to slot 0 ----
  always_comb begin : ready_chain
    logic room;
    adv  = '0;
    room = out_ready && !flush;
    for (int i = LAST; i >= 0; i--) begin
      adv[i] = valid_q[i] && room;
      // The slot behind has room if this one is empty or moving on.
      room   = !valid_q[i] || room;
    end
    in_ready = room && !flush;
  end

  assign out_valid = valid_q[LAST] && !flush;
  assign emit      = out_valid && out_ready;
  assign take      = in_valid && in_ready;

  // ---- slot next-state ----
  always_comb begin : slot_next
    valid_d = valid_q;
    for (int i = 0; i < STAGES; i++) begin
      data_d[i] = data_q[i];
      ctrl_d[i] = ctrl_q[i];
    end

    if (take) begin
      valid_d[0] = 1'b1;
      data_d[0]  = in_data;
      ctrl_d[0]  = in_ctrl;
    end else if (adv[0]) begin
      valid_d[0] = 1'b0;
      data_d[0]  = clr_data(data_q[0]);
      ctrl_d[0]  = '0;
    end

    for (int i = 1; i < STAGES; i++) begin
      if (adv[i-1]) begin
        valid_d[i] = 1'b1;
        data_d[i]  = data_q[i-1];
        ctrl_d[i]  = ctrl_q[i-1];
      end else if (adv[i]) begin
        valid_d[i] = 1'b0;
        data_d[i]  = clr_data(data_q[i]);
        ctrl_d[i]  = '0;
      end
    end

    if (flush) begin
      valid_d = '0;
      for (int i = 0; i < STAGES; i++) begin
        data_d[i] = clr_data(data_q[i]);
        ctrl_d[i] = '0;
      end
    end
  end

  // Occupancy is tracked by transfers rather than by popcount of valid bits.
  always_comb begin : occ_next
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (take && !emit) begin
      occ_d = occ_q + 4'd1;
    end else if (!take && emit) begin
      occ_d = occ_q - 4'd1;
    end
  end

  // ---- slot registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < STAGES; i++) ctrl_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      for (int i = 0; i < STAGES; i++) ctrl_q[i] <= ctrl_d[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < STAGES; i++) begin
      if (rst && (DATA_RST_EN != 0)) data_q[i] <= '0;
      else                           data_q[i] <= data_d[i];
    end
  end

  assign out_data  = data_q[LAST];
  assign out_ctrl  = out_valid ? ctrl_q[LAST] : '0;
  assign occupancy = occ_q;

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [31:0] stall_q, bubble_q;
  logic [15:0] flush_q;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---- performance counters ----
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      if (out_valid && !out_ready) stall_q  <= sat_inc32(stall_q);
      if (!out_valid && !flush)    bubble_q <= sat_inc32(bubble_q);
      if (flush)                   flush_q  <= sat_inc16(flush_q);
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
  assign flush_cnt  = flush_q;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
module tb_pipe_stage_elastic;

  localparam int STAGES = 3;
  localparam int DW     = 32;
  localparam int CW     = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          flush;
  logic [3:0]    occupancy;
`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   bubble_cnt;
  logic [15:0]   flush_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    int            e;   // edge index at which the beat was accepted
  } beat_t;

  beat_t sb[$];

  pipe_stage_elastic #(
    .DATA_W(DW), .CTRL_W(CW), .STAGES(STAGES), .DATA_RST_EN(1)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .flush(flush), .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input logic [DW-1:0] base, input logic [CW-1:0] c);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + DW'(i);
      in_ctrl  = c;
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Scoreboard monitor: the reference is a FIFO of accepted beats. The oldest
  // beat never waits behind anything until it reaches the last slot, so it is
  // visible once STAGES-1 edges have passed since it was accepted.
  always @(negedge clk) begin
    beat_t b;
    bit    exp_ov, exp_ir;
    if (rst) begin
      sb.delete();
    end else begin
      exp_ov = !flush && (sb.size() > 0) && ((cyc - sb[0].e) >= STAGES - 1);
      exp_ir = !flush && ((sb.size() < STAGES) || (exp_ov && out_ready));
      chk("occupancy", occupancy, sb.size());
      chk("out_valid", out_valid, exp_ov);
      chk("in_ready", in_ready, exp_ir);
      if (!out_valid) chk("out_ctrl_idle", out_ctrl, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: actual data=%0h required no beat", out_data);
        end else begin
          b = sb.pop_front();
          chk("out_data", out_data, b.d);
          chk("out_ctrl", out_ctrl, b.c);
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back('{in_data, in_ctrl, cyc + 1});
    end
  end

  initial begin
    int n;
    int maxocc;
`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [31:0] s0;
`endif
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    out_ready = 1'b0; flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    tick();

    // Streaming with no backpressure.
    out_ready = 1'b1;
    maxocc = 0;
    for (int k = 0; k < 8; k++) begin
      in_valid = (k < 3);
      in_data  = 32'h10 + DW'(k);
      in_ctrl  = CW'(k + 1);
      @(negedge clk);
      if (int'(occupancy) > maxocc) maxocc = int'(occupancy);
      if (k >= 3 && k <= 5) begin
        chk("stream_valid", out_valid, 1);
        chk("stream_data", out_data, 32'h10 + DW'(k - 3));
      end else begin
        chk("stream_idle", out_valid, 0);
      end
      tick();
    end
    in_valid = 1'b0;
    chk("stream_occ_peak", maxocc, STAGES);

    // Backpressure: only STAGES beats fit.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      in_data = 32'h20 + DW'(n);
      in_ctrl = CW'(n + 1);
      @(negedge clk);
      if (in_ready) n++;
      tick();
    end
    in_data = 32'h20 + DW'(n);
    in_ctrl = CW'(n + 1);
    @(negedge clk);
    chk("bp_accepted", n, STAGES);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_occ", occupancy, STAGES);
`ifdef PIPE_STAGE_PERF_CNT_EN
    s0 = stall_cnt;
    repeat (5) tick();
    @(negedge clk);
    chk("perf_stall5", stall_cnt - s0, 5);
`endif
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_data", out_data, 32'h20);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_full_swap_occ", occupancy, STAGES);
    tick();
    repeat (5) tick();

    // Flush with two beats in flight.
    out_ready = 1'b0;
    send(2, 32'h30, 6'h3F);
    @(negedge clk);
    chk("fl_pre_occ", occupancy, 2);
    tick();
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 32'h99;
    @(negedge clk);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("fl_occ", occupancy, 0);
    chk("fl_out_ctrl", out_ctrl, 0);
    chk("fl_out_valid_after", out_valid, 0);
    tick();
    repeat (4) tick();

    // Reset while full and stalled.
    out_ready = 1'b0;
    send(STAGES, 32'h40, 6'h15);
    @(negedge clk);
    chk("rs_full_occ", occupancy, STAGES);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rs_out_valid", out_valid, 0);
    chk("rs_in_ready", in_ready, 1);
    chk("rs_out_ctrl", out_ctrl, 0);
    chk("rs_out_data", out_data, 0);
    chk("rs_occ", occupancy, 0);
`ifdef PIPE_STAGE_PERF_CNT_EN
    chk("rs_stall_cnt", stall_cnt, 0);
`endif
    tick();

    // Randomized traffic with phases of varying backpressure.
    for (int i = 0; i < 10000; i++) begin
      int bias;
      bias      = (i / 2000) % 4;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) <= bias);
      flush     = ($urandom_range(0, 63) == 0);
      rst       = ($urandom_range(0, 999) == 0);
      in_data   = $urandom;
      in_ctrl   = CW'($urandom);
      tick();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (STAGES + 2) tick();
    @(negedge clk);
    #1;
    chk("drain_scoreboard", sb.size(), 0);
    chk("drain_occ", occupancy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor of the fixed MEM/WB register: an N-deep elastic pipeline register carrying a data bundle and a control bundle.
- Each slot has a valid bit and a valid/ready handshake on both ends.
- Supports stall (backpressure), flush, and bubble insertion; control bits are zeroed in empty slots so no register write or CSR side effect leaks downstream.
- Instantiated between any two core stages (EX/MEM, MEM/WB, …) in place of ad-hoc per-stage registers.

Parameters:
- DATA_W, 128, width of data bundle (pc, alu result, immediate, …), bits
- CTRL_W, 6, width of control bundle (wb_sel, wb_sel_csr, reg_write_en, …), bits
- STAGES, 1, number of register slots in series; legal range 1..8
- DATA_RST_EN, 0, 1 = data fields also cleared on reset/flush; 0 = data holds (area saving)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream has a beat
- in_ready  out  1  slot 0 can accept this cycle
- in_data  in  DATA_W  upstream data bundle
- in_ctrl  in  CTRL_W  upstream control bundle
- out_valid  out  1  last slot holds a valid beat
- out_ready  in  1  downstream accepts this cycle
- out_data  out  DATA_W  data of last slot
- out_ctrl  out  CTRL_W  control of last slot; all-zero whenever out_valid=0
- flush  in  1  kill every in-flight beat
- occupancy  out  4  number of valid slots, 0..STAGES

Behaviour:
- Reset (rst=1 at edge):
  - All slot valids=0, all ctrl=0.
  - Data=0 only if DATA_RST_EN=1.
  - Outputs after reset: out_valid=0, out_ctrl=0, occupancy=0, in_ready=1.
- Slot i advances when valid[i]=1 and (i is last ? out_ready : slot i+1 is empty or advancing). Ready is computed from last slot back to slot 0, combinationally.
- in_ready = !valid[0] || advance[0], masked to 0 while flush=1.
- Input transfer: in_valid && in_ready at the edge loads slot 0 with in_data/in_ctrl and sets valid[0]=1.
- Output transfer: out_valid && out_ready.
- Slot left empty at an edge: valid=0, ctrl=0. Data holds unless DATA_RST_EN=1.
- Latency: a beat accepted at edge k shows on out_* after edge k+STAGES-1 (visible in the cycle after that edge) when no backpressure. Throughput is 1 beat/cycle sustained.
- Backpressure: with out_ready=0, beats compress into empty slots. in_ready drops only when all STAGES slots are valid and the last slot is not draining. Data and ctrl of a stalled slot are held bit-exact.
- Simultaneous accept and emit when full: allowed; occupancy is unchanged.
- flush=1 in a cycle:
  - out_valid forced 0 combinationally and in_ready forced 0, so no handshake completes on either side.
  - At the edge, all valids and ctrl are cleared. occupancy=0 next cycle.
- flush has priority over in_valid/out_ready. rst has priority over flush.
- Reset or flush mid-stall: pending beats are discarded and never emitted.
- occupancy is a registered count: +1 on input transfer, −1 on output transfer, both/neither → unchanged. It never exceeds STAGES and never underflows.
- in_ctrl is registered even when in_valid=0 only if the slot is loaded; no other path writes ctrl.

Optional Feature:
- Macro PIPE_STAGE_PERF_CNT_EN.
- When defined, three extra outputs exist:
  - stall_cnt (32b): cycles with out_valid && !out_ready
  - bubble_cnt (32b): cycles with !out_valid && !flush
  - flush_cnt (16b): cycles with flush=1
- All counters saturate at max, are cleared by rst, and are updated at the edge following the counted cycle.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- STAGES=3, out_ready=1, stream beats data=0x10,0x11,0x12 on consecutive cycles → out_valid on cycles 3,4,5 with data 0x10,0x11,0x12; occupancy peaks at 3.
- STAGES=2, out_ready=0, offer 3 beats → first 2 accepted, in_ready=0 on 3rd; occupancy=2. Raise out_ready → beats emerge in order, 3rd accepted same cycle first one leaves.
- STAGES=2, two valid beats in flight with ctrl=6'h3F, assert flush one cycle → out_valid=0 that cycle, next cycle occupancy=0 and out_ctrl=0, no beat ever emitted.
- Assert rst while full and stalled (out_ready=0) → next cycle out_valid=0, in_ready=1, out_ctrl=0; DATA_RST_EN=1 also gives out_data=0.
- Random in_valid/out_ready 10k cycles, STAGES=1..8 → scoreboard order/content match, no loss/duplication, occupancy always equals accepted − emitted.
- With PIPE_STAGE_PERF_CNT_EN, hold out_ready=0 for 5 cycles with full pipe → stall_cnt=5; preset to 0xFFFFFFFF → stays saturated.
